// File: rtl/io_port_endpoint.sv
// io_bus port endpoint: strobe-edge RX capture into a FIFO,
// and timed strobe-pulse TX of peripheral words back to the CPU.
module io_port_endpoint #(
  parameter int WORD_SIZE     = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WORD_SIZE:0]            bus_in,
  output logic [WORD_SIZE:0]            bus_out,
  output logic [WORD_SIZE-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overflow,
  input  logic                          ovf_clear,
  input  logic [WORD_SIZE-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STROBE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } tx_state_t;

  logic                 strobe_in;
  logic                 prev_strobe;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic                 drop;
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];

  assign strobe_in = bus_in[WORD_SIZE];
  assign push      = strobe_in & ~prev_strobe;
  assign rx_count  = wptr - rptr;
  assign rx_valid  = rx_count != '0;
  assign full      = rx_count == PW'(FIFO_DEPTH);
  assign pop       = rx_valid & rx_ready;
  // a pop frees the slot the push lands in, so full+pop still writes
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign rx_data   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_strobe <= 1'b1;
      wptr        <= '0;
      rptr        <= '0;
      rx_overflow <= 1'b0;
    end else begin
      prev_strobe <= strobe_in;
      if (wr_en)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      if (drop)
        rx_overflow <= 1'b1;
      else if (ovf_clear)
        rx_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr[AW-1:0]] <= bus_in[WORD_SIZE-1:0];
  end

  tx_state_t            state;
  tx_state_t            state_d;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_d;
  logic [WORD_SIZE-1:0] tx_hold;
  logic [WORD_SIZE-1:0] hold_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tx_hold <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      tx_hold <= hold_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hold_d  = tx_hold;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          hold_d  = tx_data;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CW'(STROBE_CYCLES - 1);
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt == '0)
          state_d = GAP;
        else
          cnt_d = cnt - CW'(1);
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready = (state == IDLE) & rst_n;
  assign tx_busy  = state != IDLE;
  assign bus_out  = {state == STROBE, tx_hold};

endmodule

// File: tb/tb_io_port_endpoint.sv
// Directed bench for io_port_endpoint: RX capture/FIFO,
// overflow, TX strobe timing and mid-operation reset.
module tb_io_port_endpoint;

  logic       clk;
  logic       rst_n;
  logic [8:0] bus_in;
  logic [8:0] bus_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] rx_count;
  logic       rx_overflow;
  logic       ovf_clear;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;

  int checks;
  int errors;

  io_port_endpoint #(
    .WORD_SIZE(8),
    .FIFO_DEPTH(4),
    .STROBE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_in(bus_in),
    .bus_out(bus_out),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_count(rx_count),
    .rx_overflow(rx_overflow),
    .ovf_clear(ovf_clear),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    bus_in = {1'b1, d};
    tick();
    bus_in = {1'b0, d};
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_in = '0;
    tick();
    checks++;
    if (bus_out !== 9'h000) begin
      errors++;
      $display("FAIL reset_bus_out got %h want 000", bus_out);
    end
    checks++;
    if ({rx_valid, rx_count, rx_overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_rx got v=%b c=%0d o=%b want 0 0 0",
               rx_valid, rx_count, rx_overflow);
    end
    checks++;
    if ({tx_ready, tx_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_tx got rdy=%b busy=%b want 0 0",
               tx_ready, tx_busy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_tx_ready got %b want 1", tx_ready);
    end
  endtask

  task automatic test_rx_basic();
    bus_in = {1'b1, 8'hA5};
    #1;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_no_bypass got %b want 0", rx_valid);
    end
    tick();
    bus_in = {1'b0, 8'hA5};
    checks++;
    if ({rx_valid, rx_data, rx_count} !== {1'b1, 8'hA5, 3'd1}) begin
      errors++;
      $display("FAIL rx_basic got v=%b d=%h c=%0d want 1 a5 1",
               rx_valid, rx_data, rx_count);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checks++;
    if ({rx_valid, rx_count} !== 4'b0) begin
      errors++;
      $display("FAIL rx_pop got v=%b c=%0d want 0 0", rx_valid, rx_count);
    end
  endtask

  task automatic test_rx_long();
    bus_in = {1'b1, 8'h3C};
    repeat (5) tick();
    bus_in = {1'b0, 8'h3C};
    tick();
    checks++;
    if ({rx_count, rx_data} !== {3'd1, 8'h3C}) begin
      errors++;
      $display("FAIL rx_long got c=%0d d=%h want 1 3c", rx_count, rx_data);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) push_word(8'(i));
    checks++;
    if ({rx_count, rx_overflow} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL ovf_set got c=%0d o=%b want 4 1",
               rx_count, rx_overflow);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rx_data !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_pop%0d got %h want %h", i, rx_data, 8'(i));
      end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    checks++;
    if ({rx_count, rx_overflow} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_sticky got c=%0d o=%b want 0 1",
               rx_count, rx_overflow);
    end
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", rx_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    bus_in = {1'b1, 8'h05};
    rx_ready = 1'b1;
    tick();
    bus_in = {1'b0, 8'h05};
    rx_ready = 1'b0;
    checks++;
    if ({rx_count, rx_overflow} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full_pp got c=%0d o=%b want 4 0",
               rx_count, rx_overflow);
    end
    for (int i = 2; i <= 5; i++) begin
      checks++;
      if (rx_data !== 8'(i)) begin
        errors++;
        $display("FAIL full_pp_pop%0d got %h want %h", i, rx_data, 8'(i));
      end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_pp_empty got %b want 0", rx_valid);
    end
  endtask

  task automatic test_tx_timing();
    logic [3:0] sexp;
    sexp = 4'b0110;
    tx_data = 8'h7E;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data = 8'h00;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus_out, tx_ready, tx_busy} !== {sexp[k], 8'h7E, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL tx_cyc%0d got bus=%h rdy=%b busy=%b want %h 0 1",
                 k, bus_out, tx_ready, tx_busy, {sexp[k], 8'h7E});
      end
      tick();
    end
    checks++;
    if ({bus_out, tx_ready, tx_busy} !== {9'h07E, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tx_idle got bus=%h rdy=%b busy=%b want 07e 1 0",
               bus_out, tx_ready, tx_busy);
    end
  endtask

  task automatic test_concurrent();
    tx_data = 8'h81;
    tx_valid = 1'b1;
    bus_in = {1'b1, 8'h5A};
    tick();
    tx_valid = 1'b0;
    bus_in = {1'b0, 8'h5A};
    checks++;
    if ({bus_out, rx_count, rx_data} !== {9'h081, 3'd1, 8'h5A}) begin
      errors++;
      $display("FAIL concurrent got bus=%h c=%0d d=%h want 081 1 5a",
               bus_out, rx_count, rx_data);
    end
    tick();
    checks++;
    if (bus_out !== 9'h181) begin
      errors++;
      $display("FAIL concurrent_strobe got %h want 181", bus_out);
    end
    repeat (3) tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    tx_data = 8'h42;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    bus_in = {1'b1, 8'h99};
    tick();
    checks++;
    if ({bus_out, rx_count} !== {9'h142, 3'd1}) begin
      errors++;
      $display("FAIL rst_pre got bus=%h c=%0d want 142 1",
               bus_out, rx_count);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus_out, rx_count, tx_busy, rx_valid} !== {9'h000, 3'd0, 2'b00}) begin
      errors++;
      $display("FAIL rst_mid got bus=%h c=%0d busy=%b v=%b want 000 0 0 0",
               bus_out, rx_count, tx_busy, rx_valid);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (rx_count !== 3'd0) begin
      errors++;
      $display("FAIL rst_held_strobe got %0d want 0", rx_count);
    end
    bus_in = {1'b0, 8'h99};
    tick();
    bus_in = {1'b1, 8'h66};
    tick();
    bus_in = {1'b0, 8'h66};
    checks++;
    if ({rx_count, rx_data} !== {3'd1, 8'h66}) begin
      errors++;
      $display("FAIL rst_recapture got c=%0d d=%h want 1 66",
               rx_count, rx_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_in = '0;
    rx_ready = 1'b0;
    ovf_clear = 1'b0;
    tx_data = '0;
    tx_valid = 1'b0;
    #1;
    test_reset();
    test_rx_basic();
    test_rx_long();
    test_overflow();
    test_full_push_pop();
    test_tx_timing();
    test_concurrent();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_endpoint.md
Name: io_port_endpoint

Overview:
- Device-side endpoint of one CPU io_bus port (i1..i4); it sits between a CPU port and a peripheral.
- Inbound: detects the rising edge of the CPU's strobe bit, captures the data word, and buffers it in an RX FIFO. The peripheral pops the FIFO with a valid/ready handshake.
- Outbound: accepts one word from the peripheral over valid/ready and drives it back onto the CPU's input io_bus as a timed strobe pulse.

Parameters:
- WORD_SIZE, 8, data width; matches the codebase word type.
- FIFO_DEPTH, 4, RX FIFO entries; power of two, at least 2.
- STROBE_CYCLES, 2, number of clk cycles the TX strobe is held high; at least 1.

Ports:
- clk  input  1  system clock; every register is updated on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- bus_in  input  WORD_SIZE+1  from the CPU; packed {strobe, data}, strobe is the MSB.
- bus_out  output  WORD_SIZE+1  to the CPU; packed {strobe, data}.
- rx_data  output  WORD_SIZE  head of the RX FIFO.
- rx_valid  output  1  RX FIFO is not empty.
- rx_ready  input  1  peripheral pops the head when rx_valid and rx_ready are both high.
- rx_count  output  $clog2(FIFO_DEPTH)+1  current RX FIFO occupancy.
- rx_overflow  output  1  sticky: a word was dropped because the FIFO was full.
- ovf_clear  input  1  clears rx_overflow.
- tx_data  input  WORD_SIZE  word to send to the CPU.
- tx_valid  input  1  peripheral offers tx_data.
- tx_ready  output  1  endpoint accepts tx_data in this cycle.
- tx_busy  output  1  TX state machine is not in IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - bus_out=0, rx_valid=0, rx_count=0, rx_overflow=0, tx_ready=0, tx_busy=0.
  - FIFO pointers go to 0; the TX state machine goes to IDLE.
  - prev_strobe is set to 1, so a strobe that is already high when reset is released is not captured.
- Reset mid-operation: an in-flight TX word and all FIFO contents are discarded; the TX strobe drops at that same edge.
- RX edge detect: push = bus_in.strobe & ~prev_strobe. prev_strobe is registered from bus_in.strobe every cycle.
- RX latency: on a push in cycle N, data is written at the end of cycle N; rx_valid and rx_data are visible in cycle N+1. There is no same-cycle bypass from bus_in to rx_data.
- Pop: when rx_valid & rx_ready, the read pointer advances at the end of the cycle.
- Pointer wrap: pointers are ($clog2(FIFO_DEPTH)+1) bits and wrap naturally.
  - Full means occupancy equals FIFO_DEPTH.
  - rx_count is write pointer minus read pointer.
- Push while full with a pop in the same cycle: both are accepted and the count stays at FIFO_DEPTH.
- Push while full without a pop: the word is dropped, rx_overflow is set, and FIFO contents are unchanged.
- Push while empty: only the push takes effect, because a pop cannot happen when the FIFO is empty.
- rx_overflow: cleared by ovf_clear. If ovf_clear and a new overflow occur in the same cycle, rx_overflow stays 1.
- TX state machine:
  - IDLE: tx_ready=1. On tx_valid, latch tx_data into tx_hold and go to SETUP.
  - SETUP: 1 cycle. bus_out = {0, tx_hold}.
  - STROBE: STROBE_CYCLES cycles, counted by a down-counter. bus_out = {1, tx_hold}.
  - GAP: 1 cycle. bus_out = {0, tx_hold}, then return to IDLE.
- tx_ready is 0 in SETUP, STROBE and GAP. tx_busy is high in those same states.
- In IDLE, bus_out.data holds the last transmitted word (0 after reset) and bus_out.strobe is 0.
- TX throughput: a new word can be accepted at most every STROBE_CYCLES+3 cycles, i.e. every 5 cycles at the defaults.
- Data stability: data on bus_out is stable from SETUP through GAP, so the CPU may sample it on either strobe edge.
- Independence: the RX and TX paths share only clk and rst_n. Simultaneous RX and TX activity has no interaction.

Test Plan:
- RX basic: with the FIFO empty, drive bus_in = {1,8'hA5} for 1 cycle, then {0,8'hA5}. Required: one cycle later rx_valid=1, rx_data=A5, rx_count=1. Popping with rx_ready=1 for one cycle returns rx_count to 0.
- RX long strobe: hold the strobe high for 5 cycles with data 8'h3C. Required: exactly one entry is captured, rx_count=1.
- RX overflow: push 5 words 01..05 with rx_ready=0. Required: rx_count=4 and rx_overflow=1. Pops return 01,02,03,04. Then ovf_clear=1 for one cycle gives rx_overflow=0.
- RX full with simultaneous push and pop: FIFO full with 01..04, push 05 while popping. Required: rx_count stays 4, and the pop order continues 02,03,04,05.
- TX timing: in IDLE, tx_valid=1 with tx_data=8'h7E for 1 cycle. Required:
  - bus_out.strobe is low, high, high, low over the next 4 cycles (SETUP, STROBE, STROBE, GAP).
  - bus_out.data=7E throughout those 4 cycles.
  - tx_ready=0 for those 4 cycles and 1 on the 5th.
- Reset behaviour: assert rst_n=0 during STROBE while bus_in.strobe is held high. Required:
  - At the next edge, bus_out=0, rx_count=0 and tx_busy=0.
  - After releasing rst_n with bus_in.strobe still high, no capture occurs.
  - A later low-to-high strobe on bus_in is captured normally.
